chan_arbiter: RTL and testbench
===============================

Name: chan_arbiter

Overview:
- Collects data blocks from NCH single-channel processors and merges them into one 16-bit output stream for the GTP/readout link.
- Polls channels round-robin with give/have and reads one complete block per grant, using the control-word length field.
- Forwards words with registered valid, honours downstream backpressure, and flags malformed blocks.

Parameters:
NCH, 16, number of channel processors served
CHBITS, 4, width of channel pointer (clog2 NCH)
TMO, 255, max idle cycles of have inside a block before abort

Ports:
clk  in  1  125 MHz system clock
rst  in  1  asynchronous active-high reset
give  out  NCH  one-hot read request to the channels; at most one bit set
have  in  NCH  per-channel acknowledge; combinational response to give, meaning the word on din is valid and consumed
din  in  16*NCH  channel data; channel i occupies bits [16*i+15:16*i]; valid in the same cycle as have
ordy  in  1  downstream can accept a word this cycle
dout  out  16  merged output word
dvalid  out  1  dout valid strobe
cur_ch  out  CHBITS  channel currently granted or polled
err  out  1  one-clk pulse on a protocol error
blkcnt  out  16  count of completed blocks, wraps

Behaviour:
- Reset (async, rst=1): give=0, dout=0, dvalid=0, err=0, cur_ch=0, blkcnt=0, state=SCAN, ptr=0, len=0, tmo=0.
- Accept condition: acc = give[ptr] & have[ptr]. An accepted word appears on dout with dvalid=1 one clk later (registered). dvalid=0 in every other cycle.
- give[ptr] = ordy & (state==SCAN | state==BODY). When ordy=0, give=0, nothing is accepted, and the state holds.
- SCAN:
  - Drive give[ptr] for one cycle.
  - If no acc: ptr <= ptr+1 (wraps NCH-1 -> 0).
  - If acc and din[15]=1 (control word): forward the word; len <= din[8:0]; tmo <= 0.
    - len=0: err pulse, blkcnt+1, ptr+1, stay in SCAN.
    - Otherwise go to BODY.
  - If acc and din[15]=0: discard the word (no dvalid), err pulse, ptr <= ptr+1.
- BODY:
  - Hold give on ptr.
  - Each acc: forward the word, len <= len-1, tmo <= 0. A body word with bit15=1 is still forwarded and raises an err pulse.
  - If acc and len==1: blkcnt+1, ptr <= ptr+1, go to SCAN. The next poll is the following channel (round-robin fairness).
  - No acc while ordy=1: tmo+1. When tmo reaches TMO: err pulse, ptr+1, SCAN. The partial block is not padded.
  - No acc while ordy=0: tmo holds.
- A block is never interleaved with another channel's words.
- Throughput: one word per clk in BODY. SCAN costs one clk per empty channel.
- cur_ch = ptr.
- have on non-granted channels is ignored.
- Only one err pulse per cycle, even if several error causes occur together.

Decomposition:
- Package chan_arb_pkg holds:
  - CW_FLAG_BIT=15 and CW_LEN field [8:0];
  - CW_CH field [14:9];
  - state enum {SCAN, BODY};
  - word width constant 16.
- One sub-module is natural: rr_ptr, the wrap-around pointer with increment and registered cur_ch.
- The din mux and FSM stay in chan_arbiter.

Test Plan:
1. Channel 3 holds block CW=0x8604 (ch3, L=4) plus 4 data words; other channels empty; ordy=1 -> dout sequence 0x8604, d0..d3 on 5 consecutive dvalid cycles; blkcnt=1; ptr then polls ch4.
2. Channels 0 and 1 each hold one 3-word-body block; ch0 holds a second block queued -> output order ch0 block, ch1 block, then ch0 second block (round-robin, no starvation).
3. ordy toggles 1,0,1,0 during a ch2 block body -> give=0 in ordy=0 cycles; all L+1 words are delivered in order with no duplicates or drops.
4. Channel 5 presents 0x1234 in SCAN (bit15=0) -> word dropped, err=1 for one clk, ptr advances to 6.
5. Channel 7 sends CW with L=10, then have stays low for TMO cycles -> err pulse at tmo==255; return to SCAN at ch8; blkcnt unchanged.
6. Assert rst for 1 clk mid-block -> all outputs 0 asynchronously; after release, polling restarts at ch0.

Source files
------------

// File: rtl/chan_arb_pkg.sv
// chan_arbiter shared definitions.
// Control-word layout, FSM states and word width.
package chan_arb_pkg;

    localparam int WORD_W      = 16;
    localparam int CW_FLAG_BIT = 15;
    localparam int CW_LEN_MSB  = 8;
    localparam int CW_LEN_LSB  = 0;
    localparam int CW_LEN_W    = CW_LEN_MSB - CW_LEN_LSB + 1;
    localparam int CW_CH_MSB   = 14;
    localparam int CW_CH_LSB   = 9;

    typedef enum logic {
        SCAN,
        BODY
    } arb_state_t;

    function automatic logic [CW_LEN_W-1:0] cw_len(
        input logic [WORD_W-1:0] w
    );
        return w[CW_LEN_MSB:CW_LEN_LSB];
    endfunction

endpackage

// File: rtl/chan_arbiter_if.sv
// Channel-side and readout-side signals of chan_arbiter.
// master = arbiter, slave = channels plus downstream link.
interface chan_arb_if #(
    parameter int NCH    = 16,
    parameter int CHBITS = 4
);
    import chan_arb_pkg::*;

    logic [NCH-1:0]        give;
    logic [NCH-1:0]        have;
    logic [WORD_W*NCH-1:0] din;
    logic                  ordy;
    logic [WORD_W-1:0]     dout;
    logic                  dvalid;
    logic [CHBITS-1:0]     cur_ch;
    logic                  err;
    logic [15:0]           blkcnt;

    modport master (
        output give, dout, dvalid, cur_ch, err, blkcnt,
        input  have, din, ordy
    );

    modport slave (
        input  give, dout, dvalid, cur_ch, err, blkcnt,
        output have, din, ordy
    );

endinterface

// File: rtl/chan_arbiter_rr_ptr.sv
// Round-robin channel pointer, wraps NCH-1 -> 0.
// The registered pointer doubles as cur_ch.
module rr_ptr #(
    parameter int NCH    = 16,
    parameter int CHBITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [CHBITS-1:0] ptr
);

    localparam logic [CHBITS-1:0] LAST = CHBITS'(NCH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + CHBITS'(1);
        end
    end

endmodule

// File: rtl/chan_arbiter.sv
// Merges length-prefixed blocks from NCH channels into one stream.
// One whole block per grant, round-robin, with idle timeout.
module chan_arbiter
    import chan_arb_pkg::*;
#(
    parameter int NCH    = 16,
    parameter int CHBITS = 4,
    parameter int TMO    = 255
) (
    input  logic     clk,
    input  logic     rst,
    chan_arb_if.master bus
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    arb_state_t          state;
    logic [CW_LEN_W-1:0] len;
    logic [TW-1:0]       tmo;
    logic [CHBITS-1:0]   ptr;
    logic [WORD_W-1:0]   w;
    logic [WORD_W-1:0]   dout_q;
    logic                dvalid_q;
    logic                err_q;
    logic [15:0]         blkcnt_q;
    logic                req;
    logic                acc;
    logic                cw;
    logic                len0;
    logic                last;
    logic                tmo_hit;
    logic                inc;

    // give is masked by rst so all outputs clear asynchronously
    assign req     = bus.ordy & ~rst;
    assign bus.give = req ? (NCH'(1) << ptr) : '0;
    assign w       = bus.din[ptr*WORD_W +: WORD_W];
    assign acc     = req & bus.have[ptr];
    assign cw      = w[CW_FLAG_BIT];
    assign len0    = cw_len(w) == '0;
    assign last    = len == CW_LEN_W'(1);
    assign tmo_hit = tmo == TMO_LAST;

    always_comb begin
        inc = 1'b0;
        case (state)
            SCAN:    inc = req & (~acc | ~cw | len0);
            BODY:    inc = acc ? last : (req & tmo_hit);
            default: inc = 1'b0;
        endcase
    end

    rr_ptr #(
        .NCH    (NCH),
        .CHBITS (CHBITS)
    ) u_ptr (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .ptr (ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            len      <= '0;
            tmo      <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
            blkcnt_q <= '0;
        end else begin
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                SCAN: begin
                    if (acc && cw) begin
                        dout_q   <= w;
                        dvalid_q <= 1'b1;
                        len      <= cw_len(w);
                        tmo      <= '0;
                        if (len0) begin
                            err_q    <= 1'b1;
                            blkcnt_q <= blkcnt_q + 16'd1;
                        end else begin
                            state <= BODY;
                        end
                    end else if (acc) begin
                        err_q <= 1'b1;
                    end
                end
                BODY: begin
                    if (acc) begin
                        dout_q   <= w;
                        dvalid_q <= 1'b1;
                        len      <= len - CW_LEN_W'(1);
                        tmo      <= '0;
                        if (cw) err_q <= 1'b1;
                        if (last) begin
                            blkcnt_q <= blkcnt_q + 16'd1;
                            state    <= SCAN;
                        end
                    end else if (req) begin
                        tmo <= tmo + TW'(1);
                        // abandon a stalled block; nothing is padded
                        if (tmo_hit) begin
                            err_q <= 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.err    = err_q;
    assign bus.blkcnt = blkcnt_q;
    assign bus.cur_ch = ptr;

endmodule

// File: tb/tb_chan_arbiter.sv
// Scoreboard bench for chan_arbiter: channel queues feed the DUT,
// expected words/pointer/blkcnt are queued at load time.
module tb_chan_arbiter;
    import chan_arb_pkg::*;

    localparam int NCH    = 16;
    localparam int CHBITS = 4;
    localparam int TMO    = 255;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  ptr;
        logic [15:0] blk;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    chan_arb_if #(.NCH(NCH), .CHBITS(CHBITS)) bus ();

    chan_arbiter #(
        .NCH    (NCH),
        .CHBITS (CHBITS),
        .TMO    (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0]    chq [NCH][$];
    logic [15:0]    head [NCH];
    logic [NCH-1:0] avail;
    sb_t            exp_q [$];
    sb_t            e_m;
    int n_chk = 0, n_fail = 0, err_cnt = 0, cyc = 0;
    int err_cyc = 0, cw_cyc = 0, first_cyc = -1, last_cyc = 0;
    int e0, n;
    logic [3:0]  err_ptr = '0;
    logic [15:0] blk_m = '0;
    logic        toggle = 1'b0;

    assign bus.have = bus.give & avail;
    for (genvar i = 0; i < NCH; i++) begin : g_din
        assign bus.din[i*16 +: 16] = head[i];
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < NCH; i++)
            if (chq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // channel model: pop on accept, present new head next cycle
    always @(posedge clk) begin
        if (bus.ordy === 1'b0) chk("give_ordy0", 32'(bus.give), 32'd0);
        for (int i = 0; i < NCH; i++)
            if (bus.give[i] && bus.have[i]) void'(chq[i].pop_front());
        for (int i = 0; i < NCH; i++) begin
            avail[i] <= chq[i].size() != 0;
            head[i]  <= (chq[i].size() != 0) ? chq[i][0] : 16'h0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
            err_ptr = bus.cur_ch;
        end
        if (bus.dvalid) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (bus.dout == 16'h8E0A) cw_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("sb_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                e_m = exp_q.pop_front();
                chk("dout", 32'(bus.dout), 32'(e_m.w));
                chk("cur_ch", 32'(bus.cur_ch), 32'(e_m.ptr));
                chk("blkcnt", 32'(bus.blkcnt), 32'(e_m.blk));
            end
        end
        bus.ordy = toggle ? ~bus.ordy : 1'b1;
    end

    task automatic push_block(int ch, int len, logic [15:0] base);
        sb_t e;
        e.w = 16'h8000 | 16'(ch << 9) | 16'(len);
        chq[ch].push_back(e.w);
        if (len == 0) begin
            blk_m++;
            e.ptr = 4'((ch + 1) % NCH);
        end else begin
            e.ptr = 4'(ch);
        end
        e.blk = blk_m;
        exp_q.push_back(e);
        for (int k = 0; k < len; k++) begin
            e.w = base + 16'(k);
            chq[ch].push_back(e.w);
            if (k == len - 1) begin
                blk_m++;
                e.ptr = 4'((ch + 1) % NCH);
            end else begin
                e.ptr = 4'(ch);
            end
            e.blk = blk_m;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(string tag, int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy()) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ptr(logic [3:0] v);
        int k = 0;
        while (bus.cur_ch != v && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_ptr", 32'(bus.cur_ch), 32'(v));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sb_t e;
        repeat (3) @(negedge clk);
        chk("rst_give", 32'(bus.give), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_dvalid", 32'(bus.dvalid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_cur_ch", 32'(bus.cur_ch), 32'd0);
        chk("rst_blkcnt", 32'(bus.blkcnt), 32'd0);
        rst = 1'b0;

        // single block on ch3
        first_cyc = -1;
        push_block(3, 4, 16'h0D00);
        drain("t1_drain", 200);
        chk("t1_span", 32'(last_cyc - first_cyc), 32'd4);
        chk("t1_blkcnt", 32'(bus.blkcnt), 32'd1);

        // round-robin: ch0, ch1, ch0 again
        e0 = err_cnt;
        wait_ptr(4'd8);
        push_block(0, 3, 16'h0A00);
        push_block(1, 3, 16'h0B00);
        push_block(0, 3, 16'h0A10);
        drain("t2_drain", 300);
        chk("t2_err", 32'(err_cnt - e0), 32'd0);

        // backpressure toggling during a ch2 block
        e0 = err_cnt;
        wait_ptr(4'd8);
        toggle = 1'b1;
        push_block(2, 5, 16'h0C00);
        drain("t3_drain", 300);
        toggle = 1'b0;
        @(negedge clk);
        chk("t3_err", 32'(err_cnt - e0), 32'd0);

        // stray data word in SCAN
        e0 = err_cnt;
        chq[5].push_back(16'h1234);
        drain("t4_drain", 100);
        chk("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t4_err_ptr", 32'(err_ptr), 32'd6);
        chk("t4_blkcnt", 32'(bus.blkcnt), 32'(blk_m));

        // ch7 stalls after its control word
        e0 = err_cnt;
        chq[7].push_back(16'h8E0A);
        e.w = 16'h8E0A;
        e.ptr = 4'd7;
        e.blk = blk_m;
        exp_q.push_back(e);
        n = 0;
        while (err_cnt == e0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("t5_err_seen", 32'(n < 600), 32'd1);
        chk("t5_tmo_len", 32'(err_cyc - cw_cyc), 32'd255);
        chk("t5_err_ptr", 32'(err_ptr), 32'd8);
        repeat (3) @(negedge clk);
        chk("t5_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t5_blkcnt", 32'(bus.blkcnt), 32'(blk_m));
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // zero-length block and flagged body words
        e0 = err_cnt;
        wait_ptr(4'd8);
        push_block(9, 0, 16'h0000);
        push_block(10, 2, 16'h8AB0);
        drain("t7_drain", 200);
        chk("t7_err_cnt", 32'(err_cnt - e0), 32'd3);
        chk("t7_blkcnt", 32'(bus.blkcnt), 32'(blk_m));

        // reset in the middle of a ch12 block
        wait_ptr(4'd8);
        push_block(12, 6, 16'h0E00);
        n = 0;
        while (exp_q.size() > 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_mid_block", 32'(n < 200), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_give", 32'(bus.give), 32'd0);
        chk("t6_dout", 32'(bus.dout), 32'd0);
        chk("t6_dvalid", 32'(bus.dvalid), 32'd0);
        chk("t6_err", 32'(bus.err), 32'd0);
        chk("t6_cur_ch", 32'(bus.cur_ch), 32'd0);
        chk("t6_blkcnt", 32'(bus.blkcnt), 32'd0);
        chq[12].delete();
        exp_q.delete();
        blk_m = '0;
        @(negedge clk);
        rst = 1'b0;
        e0 = err_cnt;
        #1 chk("t6_ptr0", 32'(bus.cur_ch), 32'd0);
        @(negedge clk);
        chk("t6_ptr1", 32'(bus.cur_ch), 32'd1);
        repeat (40) @(negedge clk);
        chk("t6_quiet_err", 32'(err_cnt - e0), 32'd0);
        chk("t6_blk_after", 32'(bus.blkcnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
